editor_campos_rtc: RTL and testbench

Parametrised field editor for the RTC user interface. It holds NFIELDS editable values (date, time and timer fields) and moves an edit cursor between them with Left/Right. It increments or decrements the selected field with per-field minimum/maximum wrap-around and hold-to-repeat, and emits a commit pulse when editing ends. It sits between the debounced push-button/switch inputs and the RTC write controller / display formatter.

---
 rtl/editor_campos_rtc.sv | 194 +++++++++++++++++++
 tb/tb_editor_campos_rtc.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/editor_campos_rtc.sv
`default_nettype none
// ============================================================================
// Module   : editor_campos_rtc
// Brief    : RTC field editor. It moves a cursor across the fields, steps
//            values with min/max wrap and hold-to-repeat, and pulses a commit
//            when an edit session ends.
// Revision : 1.0 - initial release
// ============================================================================
module editor_campos_rtc #(
    parameter int WIDTH       = 8,
    parameter int NFIELDS     = 7,
    parameter logic [NFIELDS*WIDTH-1:0] MIN_VALS =
        {8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd1, 8'd1},
    parameter logic [NFIELDS*WIDTH-1:0] MAX_VALS =
        {8'd59, 8'd23, 8'd59, 8'd23, 8'd99, 8'd12, 8'd31},
    parameter int HOLD_CYCLES = 50_000_000,
    parameter int RATE_CYCLES = 10_000_000,
    parameter int CW          = $clog2(NFIELDS)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     edit_en,
    input  logic                     left,
    input  logic                     right,
    input  logic                     inc,
    input  logic                     dec,
    input  logic                     load,
    input  logic [NFIELDS*WIDTH-1:0] load_data,
    output logic [CW-1:0]            cursor,
    output logic [NFIELDS*WIDTH-1:0] fields,
    output logic                     editing,
    output logic                     dirty,
    output logic                     commit
);

    localparam int CNT_MAX = (HOLD_CYCLES > RATE_CYCLES) ? HOLD_CYCLES : RATE_CYCLES;
    localparam int CNTW    = $clog2(CNT_MAX + 1);

    localparam logic [CNTW-1:0] c_hold = CNTW'(HOLD_CYCLES);
    localparam logic [CNTW-1:0] c_rate = CNTW'(RATE_CYCLES);
    localparam logic [CNTW-1:0] c_one  = CNTW'(1);
    localparam logic [CW-1:0]   c_last = CW'(NFIELDS - 1);

    localparam logic [0:0] S_IDLE = 1'd0;
    localparam logic [0:0] S_EDIT = 1'd1;

    logic [0:0]               r_state;
    logic [0:0]               w_state_nxt;
    logic                     r_left, r_right, r_inc, r_dec;
    logic [NFIELDS*WIDTH-1:0] r_fields;
    logic [CW-1:0]            r_cursor;
    logic                     r_dirty;
    logic                     r_commit;
    logic                     r_rep_active;
    logic                     r_repeating;
    logic [CNTW-1:0]          r_rep_cnt;

    logic                     w_active;
    logic                     w_left_p, w_right_p, w_inc_p, w_dec_p;
    logic                     w_cur_any, w_single, w_rep_fire, w_step;
    logic [CNTW-1:0]          w_thr;
    logic [CW-1:0]            w_cur_nxt;
    int                       w_base;
    logic [WIDTH-1:0]         w_cur_val, w_min, w_max, w_new;
    logic                     w_oor;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (edit_en)  w_state_nxt = S_EDIT;
            S_EDIT:  if (!edit_en) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        editing = (r_state == S_EDIT);
        cursor  = r_cursor;
        fields  = r_fields;
        dirty   = r_dirty;
        commit  = r_commit;
    end

    // Button events only count while editing and not on the exit cycle.
    always_comb begin
        w_active   = (r_state == S_EDIT) && edit_en;
        w_left_p   = w_active & left  & ~r_left;
        w_right_p  = w_active & right & ~r_right;
        w_inc_p    = w_active & inc   & ~r_inc;
        w_dec_p    = w_active & dec   & ~r_dec;
        w_cur_any  = w_left_p | w_right_p;
        w_single   = inc ^ dec;
        w_thr      = r_repeating ? c_rate : c_hold;
        w_rep_fire = w_active & r_rep_active & w_single & ~w_inc_p & ~w_dec_p
                   & (r_rep_cnt == w_thr);
        w_step     = w_active & ~w_cur_any & w_single & (w_inc_p | w_dec_p | w_rep_fire);
    end

    // Cursor movement; simultaneous left+right leaves it in place.
    always_comb begin
        w_cur_nxt = r_cursor;
        if (w_left_p && !w_right_p)
            w_cur_nxt = (r_cursor == '0) ? c_last : r_cursor - 1'b1;
        else if (w_right_p && !w_left_p)
            w_cur_nxt = (r_cursor == c_last) ? '0 : r_cursor + 1'b1;
    end

    // Stepped value of the selected field; out-of-range loads snap to the bound.
    always_comb begin
        w_base    = int'(r_cursor) * WIDTH;
        w_cur_val = r_fields[w_base +: WIDTH];
        w_min     = MIN_VALS[w_base +: WIDTH];
        w_max     = MAX_VALS[w_base +: WIDTH];
        w_oor     = (w_cur_val < w_min) || (w_cur_val > w_max);
        if (inc)
            w_new = (w_oor || (w_cur_val == w_max)) ? w_min : w_cur_val + 1'b1;
        else
            w_new = (w_oor || (w_cur_val == w_min)) ? w_max : w_cur_val - 1'b1;
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_left       <= 1'b0;
            r_right      <= 1'b0;
            r_inc        <= 1'b0;
            r_dec        <= 1'b0;
            r_fields     <= MIN_VALS;
            r_cursor     <= '0;
            r_dirty      <= 1'b0;
            r_commit     <= 1'b0;
            r_rep_active <= 1'b0;
            r_repeating  <= 1'b0;
            r_rep_cnt    <= '0;
        end else begin
            r_left   <= left;
            r_right  <= right;
            r_inc    <= inc;
            r_dec    <= dec;
            r_commit <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (load) r_fields <= load_data;
                    if (edit_en) begin
                        r_cursor <= '0;
                        r_dirty  <= 1'b0;
                    end
                end
                S_EDIT: begin
                    if (!edit_en) begin
                        r_commit <= r_dirty;
                        r_dirty  <= 1'b0;
                    end else begin
                        r_cursor <= w_cur_nxt;
                        if (w_step) begin
                            r_fields[w_base +: WIDTH] <= w_new;
                            r_dirty                   <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase

            // Hold counter is armed only by a fresh inc/dec press.
            if (!w_active || w_cur_any || !w_single) begin
                r_rep_active <= 1'b0;
                r_repeating  <= 1'b0;
                r_rep_cnt    <= '0;
            end else if (w_inc_p || w_dec_p) begin
                r_rep_active <= 1'b1;
                r_repeating  <= 1'b0;
                r_rep_cnt    <= c_one;
            end else if (r_rep_active) begin
                if (r_rep_cnt == w_thr) begin
                    r_repeating <= 1'b1;
                    r_rep_cnt   <= c_one;
                end else begin
                    r_rep_cnt <= r_rep_cnt + 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_editor_campos_rtc.sv
`default_nettype none
// ============================================================================
// Module   : tb_editor_campos_rtc
// Brief    : Directed self-checking bench for editor_campos_rtc.
// Revision : 1.0 - initial release
// ============================================================================
module tb_editor_campos_rtc;

    localparam int WIDTH   = 8;
    localparam int NFIELDS = 7;
    localparam int CW      = 3;

    logic                     clk = 1'b0;
    logic                     reset, edit_en, left, right, inc, dec, load;
    logic [NFIELDS*WIDTH-1:0] load_data;
    logic [CW-1:0]            cursor;
    logic [NFIELDS*WIDTH-1:0] fields;
    logic                     editing, dirty, commit;

    int n_cmp = 0;
    int n_err = 0;

    localparam logic [NFIELDS*WIDTH-1:0] c_reset_fields =
        {8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd1, 8'd1};
    localparam logic [NFIELDS*WIDTH-1:0] c_load1 =
        {8'd7, 8'd3, 8'd0, 8'd30, 8'd0, 8'd12, 8'd5};

    editor_campos_rtc #(
        .WIDTH      (WIDTH),
        .NFIELDS    (NFIELDS),
        .HOLD_CYCLES(4),
        .RATE_CYCLES(2)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .edit_en  (edit_en),
        .left     (left),
        .right    (right),
        .inc      (inc),
        .dec      (dec),
        .load     (load),
        .load_data(load_data),
        .cursor   (cursor),
        .fields   (fields),
        .editing  (editing),
        .dirty    (dirty),
        .commit   (commit)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [WIDTH-1:0] fld(input int i);
        return fields[i*WIDTH +: WIDTH];
    endfunction

    // Press a single button for one cycle, then release it for one cycle.
    task automatic tap(input int which);
        case (which)
            0: left  = 1'b1;
            1: right = 1'b1;
            2: inc   = 1'b1;
            default: dec = 1'b1;
        endcase
        tick();
        left = 1'b0; right = 1'b0; inc = 1'b0; dec = 1'b0;
        tick();
    endtask

    initial begin
        reset = 1'b1; edit_en = 1'b0; left = 1'b0; right = 1'b0;
        inc = 1'b0; dec = 1'b0; load = 1'b0; load_data = '0;
        tick(); tick();
        reset = 1'b0;
        check("rst_fields",  64'(fields),  64'(c_reset_fields));
        check("rst_cursor",  64'(cursor),  64'd0);
        check("rst_editing", 64'(editing), 64'd0);
        check("rst_dirty",   64'(dirty),   64'd0);
        check("rst_commit",  64'(commit),  64'd0);

        // Enter edit, one inc on day
        edit_en = 1'b1; tick();
        check("enter_editing", 64'(editing), 64'd1);
        inc = 1'b1; tick();
        check("inc_day",      64'(fld(0)), 64'd2);
        check("inc_dirty",    64'(dirty),  64'd1);
        check("inc_cursor",   64'(cursor), 64'd0);
        inc = 1'b0; tick();

        // Cursor wrap
        left = 1'b1; tick();
        check("left_wrap", 64'(cursor), 64'd6);
        left = 1'b0; tick();
        right = 1'b1; tick();
        check("right_wrap", 64'(cursor), 64'd0);
        right = 1'b0; tick();

        // Exit with dirty -> one-cycle commit
        edit_en = 1'b0; tick();
        check("exit_commit",  64'(commit),  64'd1);
        check("exit_dirty",   64'(dirty),   64'd0);
        check("exit_editing", 64'(editing), 64'd0);
        tick();
        check("commit_single", 64'(commit), 64'd0);

        // Load in IDLE, out-of-range hour stored as-is
        load_data = c_load1; load = 1'b1; tick();
        load = 1'b0;
        check("load_fields", 64'(fields), 64'(c_load1));

        // Field wrap cases
        edit_en = 1'b1; tick();
        tap(1);
        check("cur_month", 64'(cursor), 64'd1);
        tap(2);
        check("month_wrap", 64'(fld(1)), 64'd1);
        tap(1);
        tap(3);
        check("year_wrap", 64'(fld(2)), 64'd99);
        tap(1);
        tap(2);
        check("hour_oor_inc", 64'(fld(3)), 64'd0);
        tap(1);
        check("cur_min", 64'(cursor), 64'd4);

        // Auto-repeat: steps at hold cycles 0,4,6,8
        inc = 1'b1; tick();
        check("rep_c0", 64'(fld(4)), 64'd1);
        repeat (3) tick();
        check("rep_c3", 64'(fld(4)), 64'd1);
        tick();
        check("rep_c4", 64'(fld(4)), 64'd2);
        repeat (5) tick();
        check("rep_c9", 64'(fld(4)), 64'd4);
        inc = 1'b0; tick();
        check("rep_release", 64'(fld(4)), 64'd4);
        tick();
        dec = 1'b1; tick();
        check("dec_after_rep", 64'(fld(4)), 64'd3);
        dec = 1'b0; tick();

        // Simultaneous events
        left = 1'b1; right = 1'b1; tick();
        check("lr_same", 64'(cursor), 64'd4);
        left = 1'b0; right = 1'b0; tick();
        right = 1'b1; inc = 1'b1; tick();
        check("right_inc_cur", 64'(cursor), 64'd5);
        check("right_inc_min", 64'(fld(4)), 64'd3);
        check("right_inc_th",  64'(fld(5)), 64'd3);
        right = 1'b0; inc = 1'b0; tick();
        inc = 1'b1; dec = 1'b1;
        repeat (20) tick();
        check("incdec_hold", 64'(fld(5)), 64'd3);
        inc = 1'b0; dec = 1'b0; tick();

        // load ignored in EDIT
        load_data = '0; load = 1'b1; tick();
        load = 1'b0;
        check("load_ign_day", 64'(fld(0)), 64'd5);

        edit_en = 1'b0; tick();
        check("exit2_commit", 64'(commit), 64'd1);
        tick();
        check("exit2_single", 64'(commit), 64'd0);

        // Edit session without a step -> no commit
        edit_en = 1'b1; tick(); tick();
        edit_en = 1'b0; tick();
        check("nostep_commit", 64'(commit), 64'd0);

        // Button held across EDIT entry is not a press
        inc = 1'b1; tick();
        edit_en = 1'b1; tick(); tick(); tick();
        check("held_entry_day",   64'(fld(0)), 64'd5);
        check("held_entry_dirty", 64'(dirty),  64'd0);
        inc = 1'b0; tick();
        inc = 1'b1; tick();
        check("repress_day", 64'(fld(0)), 64'd6);
        inc = 1'b0;

        // Reset mid-edit
        reset = 1'b1; edit_en = 1'b0; tick();
        check("midrst_fields",  64'(fields),  64'(c_reset_fields));
        check("midrst_cursor",  64'(cursor),  64'd0);
        check("midrst_editing", 64'(editing), 64'd0);
        check("midrst_commit",  64'(commit),  64'd0);
        reset = 1'b0; tick();
        check("midrst_commit2", 64'(commit), 64'd0);
        check("midrst_dirty",   64'(dirty),  64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
